balance_pid_gen: RTL

BALANCE_PID_GEN -- requirements
Module: balance_pid_gen

---
 rtl/bal_pkg.sv | 26 ++
 rtl/bal_integrator.sv | 31 +++
 rtl/balance_pid_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bal_pkg.sv
// Shared limits, shift amounts and saturation helper for the balance PID generator.
package bal_pkg;
    localparam int RX_W        = 10;
    localparam int INT_W       = 18;
    localparam int PTCH_MIN    = -512;
    localparam int PTCH_MAX    = 511;
    localparam int DIFF_MIN    = -128;
    localparam int DIFF_MAX    = 127;
    localparam int INT_MIN     = -131072;
    localparam int INT_MAX     = 131071;
    localparam int I_SHIFT     = 6;
    localparam int STEER_SHIFT = 3;

    function automatic logic signed [31:0] sat(
        input logic signed [31:0] v,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi
    );
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction
endpackage

// File: rtl/bal_integrator.sv
// Saturating pitch integrator; clear has priority over accumulation.
module bal_integrator
    import bal_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld,
    input  logic                    clr,
    input  logic signed [RX_W-1:0]  din,
    output logic signed [INT_W-1:0] acc_next
);
    logic signed [INT_W-1:0] acc_reg;
    logic signed [31:0]      sum;

    always_comb begin
        sum = 32'(acc_reg) + 32'(din);
        if (clr)
            acc_next = '0;
        else if (vld)
            acc_next = INT_W'(sat(sum, INT_MIN, INT_MAX));
        else
            acc_next = acc_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_reg <= '0;
        else
            acc_reg <= acc_next;
    end
endmodule

// File: rtl/balance_pid_gen.sv
// Two-stage PID balance controller producing per-wheel speed/direction.
// Steering mix is included only when BAL_STEER_EN is defined.
module balance_pid_gen
    import bal_pkg::*;
#(
    parameter int PTCH_W      = 16,
    parameter int SPD_W       = 11,
    parameter int D_DEPTH     = 2,
    parameter int P_COEFF     = 5,
    parameter int D_COEFF     = 6,
    parameter int FAST_THRESH = 1536
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld,
    input  logic signed [PTCH_W-1:0] ptch,
    input  logic signed [11:0]       ld_cell_diff,
    input  logic                     rider_off,
    input  logic                     en_steer,
    input  logic                     pwr_up,
    output logic [SPD_W-1:0]         lft_spd,
    output logic                     lft_rev,
    output logic [SPD_W-1:0]         rght_spd,
    output logic                     rght_rev,
    output logic                     too_fast,
    output logic                     out_vld
);
    localparam logic signed [31:0] SPD_LIM = 32'((1 << SPD_W) - 1);

    logic signed [RX_W-1:0]  ptch_rx;
    logic signed [RX_W-1:0]  hist_reg [D_DEPTH];
    logic signed [INT_W-1:0] acc_next;
    logic signed [31:0]      diff, p_calc, i_calc, d_calc, steer_calc;
    logic signed [31:0]      p_reg, i_reg, d_reg, steer_reg;
    logic                    s1_vld_reg;
    logic signed [31:0]      pid, lft_trq, rght_trq;
    logic [SPD_W-1:0]        lft_mag, rght_mag;

    assign ptch_rx = RX_W'(sat(32'(ptch), PTCH_MIN, PTCH_MAX));

    bal_integrator u_int (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld),
        .clr      (rider_off | ~pwr_up),
        .din      (ptch_rx),
        .acc_next (acc_next)
    );

    always_comb begin
        diff   = sat(32'(ptch_rx) - 32'(hist_reg[D_DEPTH-1]), DIFF_MIN, DIFF_MAX);
        p_calc = 32'(ptch_rx) * P_COEFF;
        i_calc = 32'(acc_next) >>> I_SHIFT;
        d_calc = diff * D_COEFF;
`ifdef BAL_STEER_EN
        steer_calc = en_steer ? (32'(ld_cell_diff) >>> STEER_SHIFT) : '0;
`else
        steer_calc = '0;
`endif
    end

`ifndef BAL_STEER_EN
    // Steering inputs stay on the port list but have no effect in this build.
    logic steer_unused;
    assign steer_unused = en_steer ^ (^ld_cell_diff);
`endif

    // Stage 1: terms and pitch history advance only on a new sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_reg <= 1'b0;
            p_reg      <= '0;
            i_reg      <= '0;
            d_reg      <= '0;
            steer_reg  <= '0;
            for (int i = 0; i < D_DEPTH; i++)
                hist_reg[i] <= '0;
        end else begin
            s1_vld_reg <= vld;
            if (vld) begin
                p_reg     <= p_calc;
                i_reg     <= i_calc;
                d_reg     <= d_calc;
                steer_reg <= steer_calc;
                for (int i = D_DEPTH - 1; i > 0; i--)
                    hist_reg[i] <= hist_reg[i-1];
                hist_reg[0] <= ptch_rx;
            end
        end
    end

    always_comb begin
        pid      = sat(p_reg + i_reg + d_reg, -SPD_LIM, SPD_LIM);
        lft_trq  = sat(pid + steer_reg, -SPD_LIM, SPD_LIM);
        rght_trq = sat(pid - steer_reg, -SPD_LIM, SPD_LIM);
        lft_mag  = SPD_W'(lft_trq[31] ? -lft_trq : lft_trq);
        rght_mag = SPD_W'(rght_trq[31] ? -rght_trq : rght_trq);
    end

    // Stage 2: outputs hold between samples; powered-down samples load zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            lft_spd  <= '0;
            lft_rev  <= 1'b0;
            rght_spd <= '0;
            rght_rev <= 1'b0;
            too_fast <= 1'b0;
        end else begin
            out_vld <= s1_vld_reg;
            if (s1_vld_reg) begin
                if (!pwr_up) begin
                    lft_spd  <= '0;
                    lft_rev  <= 1'b0;
                    rght_spd <= '0;
                    rght_rev <= 1'b0;
                    too_fast <= 1'b0;
                end else begin
                    lft_spd  <= lft_mag;
                    lft_rev  <= lft_trq[31];
                    rght_spd <= rght_mag;
                    rght_rev <= rght_trq[31];
                    too_fast <= (int'(lft_mag) > FAST_THRESH) || (int'(rght_mag) > FAST_THRESH);
                end
            end
        end
    end
endmodule
